// File: rtl/dual_port_frame_ram_if.sv
// Bus bundle for dual_port_frame_ram: write port A, read port B and status.
//   wea         per-byte write enables, port A
//   addra       write address
//   dina        write data
//   enb         read enable, port B
//   addrb       read address
//   regceb      output-register enable (two-stage read pipeline only)
//   doutb       read data
//   doutb_valid doutb holds a completed read
//   busy        clear sweep in progress
// master drives the requests; slave is the RAM.
interface dual_port_frame_ram_if #(
    parameter int RAM_WIDTH = 16,
    parameter int RAM_DEPTH = 6144
);
    localparam int ADDR_W = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
    localparam int NB     = RAM_WIDTH / 8;

    logic [NB-1:0]        wea;
    logic [ADDR_W-1:0]    addra;
    logic [RAM_WIDTH-1:0] dina;
    logic                 enb;
    logic [ADDR_W-1:0]    addrb;
    logic                 regceb;
    logic [RAM_WIDTH-1:0] doutb;
    logic                 doutb_valid;
    logic                 busy;

    modport master (
        output wea, addra, dina, enb, addrb, regceb,
        input  doutb, doutb_valid, busy
    );

    modport slave (
        input  wea, addra, dina, enb, addrb, regceb,
        output doutb, doutb_valid, busy
    );
endinterface

// File: rtl/dual_port_frame_ram.sv
// Simple dual-port frame RAM: byte-enabled write port A, registered read port B.
// Read latency is 1 cycle (LOW_LATENCY) or 2 cycles (HIGH_PERFORMANCE, stage 2 gated
// by regceb). Same-address read/write returns the old word (READ_FIRST) or the
// byte-merged new word (WRITE_FIRST). Out-of-range writes are dropped and
// out-of-range reads return 0.
// Optional feature macro FRAME_RAM_CLEAR_EN: reset starts a sweep writing CLEAR_VALUE
// to every word, one per cycle; busy is high and both ports are ignored meanwhile.
// Ports:
//   clka    single clock, rising edge
//   rsta_n  synchronous active-low reset (pipeline and sweep state only)
//   bus     dual_port_frame_ram_if slave: wea/addra/dina, enb/addrb/regceb,
//           doutb/doutb_valid, busy
module dual_port_frame_ram #(
    parameter int                   RAM_WIDTH       = 16,
    parameter int                   RAM_DEPTH       = 6144,
    parameter string                RAM_PERFORMANCE = "HIGH_PERFORMANCE",
    parameter string                COLLISION_MODE  = "READ_FIRST",
    parameter string                INIT_FILE       = "",
    parameter logic [RAM_WIDTH-1:0] CLEAR_VALUE     = '0
) (
    input logic                  clka,
    input logic                  rsta_n,
    dual_port_frame_ram_if.slave bus
);
    localparam int ADDR_W = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
    localparam int NB     = RAM_WIDTH / 8;

    localparam bit LowLatency = (RAM_PERFORMANCE == "LOW_LATENCY");
    localparam bit WriteFirst = (COLLISION_MODE == "WRITE_FIRST");

    // One extra bit so the depth itself is representable for range checks.
    localparam logic [ADDR_W:0]   DepthV   = (ADDR_W + 1)'(RAM_DEPTH);
    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(RAM_DEPTH - 1);

    logic [RAM_WIDTH-1:0] mem [RAM_DEPTH];

    logic              busy;
    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;

`ifdef FRAME_RAM_CLEAR_EN
    typedef enum logic {StIdle, StClear} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clka) begin
        if (!rsta_n) begin
            state_q <= StClear;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
            end
            StClear: begin
                if (cnt_q == LastAddr) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + ADDR_W'(1);
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign busy     = (state_q == StClear);
    // Hold the sweep while reset is asserted so it always restarts cleanly at 0.
    assign clr_we   = busy && rsta_n;
    assign clr_addr = cnt_q;
`else
    assign busy     = 1'b0;
    assign clr_we   = 1'b0;
    assign clr_addr = '0;
`endif

    // Write path: the sweep owns port A while busy.
    logic [NB-1:0]        mem_we;
    logic [ADDR_W-1:0]    mem_addr;
    logic [RAM_WIDTH-1:0] mem_wdata;
    logic                 wr_in_range;
    logic                 rd_in_range;

    assign wr_in_range = ({1'b0, bus.addra} < DepthV);
    assign rd_in_range = ({1'b0, bus.addrb} < DepthV);

    always_comb begin
        mem_we    = '0;
        mem_addr  = bus.addra;
        mem_wdata = bus.dina;
        if (busy) begin
            mem_we    = {NB{clr_we}};
            mem_addr  = clr_addr;
            mem_wdata = CLEAR_VALUE;
        end else if (rsta_n && wr_in_range) begin
            mem_we = bus.wea;
        end
    end

    always_ff @(posedge clka) begin
        for (int i = 0; i < NB; i++) begin
            if (mem_we[i]) begin
                mem[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
            end
        end
    end

    // Read word as seen by stage 1, including same-cycle write forwarding.
    logic [RAM_WIDTH-1:0] rd_word;

    always_comb begin
        rd_word = '0;
        if (rd_in_range) begin
            rd_word = mem[bus.addrb];
            if (WriteFirst && (mem_addr == bus.addrb)) begin
                for (int i = 0; i < NB; i++) begin
                    if (mem_we[i]) begin
                        rd_word[8*i +: 8] = mem_wdata[8*i +: 8];
                    end
                end
            end
        end
    end

    logic [RAM_WIDTH-1:0] s1_data_q;
    logic                 s1_valid_q;

    always_ff @(posedge clka) begin
        if (!rsta_n) begin
            s1_data_q  <= '0;
            s1_valid_q <= 1'b0;
        end else if (bus.enb && !busy) begin
            s1_data_q  <= rd_word;
            s1_valid_q <= 1'b1;
        end else begin
            s1_valid_q <= 1'b0;
        end
    end

    if (LowLatency) begin : g_low_latency
        assign bus.doutb       = s1_data_q;
        assign bus.doutb_valid = s1_valid_q;
    end else begin : g_high_perf
        logic [RAM_WIDTH-1:0] s2_data_q;
        logic                 s2_valid_q;

        always_ff @(posedge clka) begin
            if (!rsta_n) begin
                s2_data_q  <= '0;
                s2_valid_q <= 1'b0;
            end else if (bus.regceb) begin
                s2_data_q  <= s1_data_q;
                s2_valid_q <= s1_valid_q;
            end
        end

        assign bus.doutb       = s2_data_q;
        assign bus.doutb_valid = s2_valid_q;
    end

    assign bus.busy = busy;
endmodule

// File: tb/tb_dual_port_frame_ram.sv
// Bench for dual_port_frame_ram: a HIGH_PERFORMANCE/READ_FIRST and a
// LOW_LATENCY/WRITE_FIRST instance share one stimulus stream and are compared each
// cycle against a word-array reference model. With FRAME_RAM_CLEAR_EN a small
// 16-word instance exercises the clear sweep.
module tb_dual_port_frame_ram;
    localparam int W  = 16;
    localparam int D  = 6144;
    localparam int AW = 13;
    localparam int NB = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic [NB-1:0] wea;
    logic [AW-1:0] addra;
    logic [W-1:0]  dina;
    logic          enb;
    logic [AW-1:0] addrb;
    logic          regceb;

    dual_port_frame_ram_if #(.RAM_WIDTH(W), .RAM_DEPTH(D)) bus_hp ();
    dual_port_frame_ram_if #(.RAM_WIDTH(W), .RAM_DEPTH(D)) bus_ll ();

    assign bus_hp.wea    = wea;
    assign bus_hp.addra  = addra;
    assign bus_hp.dina   = dina;
    assign bus_hp.enb    = enb;
    assign bus_hp.addrb  = addrb;
    assign bus_hp.regceb = regceb;
    assign bus_ll.wea    = wea;
    assign bus_ll.addra  = addra;
    assign bus_ll.dina   = dina;
    assign bus_ll.enb    = enb;
    assign bus_ll.addrb  = addrb;
    assign bus_ll.regceb = regceb;

    dual_port_frame_ram #(
        .RAM_WIDTH(W), .RAM_DEPTH(D),
        .RAM_PERFORMANCE("HIGH_PERFORMANCE"), .COLLISION_MODE("READ_FIRST")
    ) dut_hp (.clka(clk), .rsta_n(rst_n), .bus(bus_hp));

    dual_port_frame_ram #(
        .RAM_WIDTH(W), .RAM_DEPTH(D),
        .RAM_PERFORMANCE("LOW_LATENCY"), .COLLISION_MODE("WRITE_FIRST")
    ) dut_ll (.clka(clk), .rsta_n(rst_n), .bus(bus_ll));

    // Reference model state.
    logic [W-1:0] m_mem [D];
    logic [W-1:0] ll_d, hp1_d, hp2_d;
    bit           ll_v, hp1_v, hp2_v;
    int           sweep_left;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply one clock edge to the model using the inputs currently driven.
    task automatic model_edge();
        logic [W-1:0] pre;
        logic [W-1:0] post;
        bit           busy_now;
        if (!rst_n) begin
            ll_d = '0;  ll_v = 1'b0;
            hp1_d = '0; hp1_v = 1'b0;
            hp2_d = '0; hp2_v = 1'b0;
`ifdef FRAME_RAM_CLEAR_EN
            sweep_left = D;
`endif
            return;
        end
        busy_now = (sweep_left > 0);
        if (regceb) begin
            hp2_d = hp1_d;
            hp2_v = hp1_v;
        end
        if (enb && !busy_now) begin
            pre  = '0;
            post = '0;
            if (int'(addrb) < D) begin
                pre  = m_mem[addrb];
                post = pre;
                if (addra == addrb) begin
                    for (int b = 0; b < NB; b++) begin
                        if (wea[b]) post[8*b +: 8] = dina[8*b +: 8];
                    end
                end
            end
            hp1_d = pre;  hp1_v = 1'b1;
            ll_d  = post; ll_v  = 1'b1;
        end else begin
            hp1_v = 1'b0;
            ll_v  = 1'b0;
        end
        if (busy_now) begin
            m_mem[D - sweep_left] = '0;
            sweep_left--;
        end else if (int'(addra) < D) begin
            for (int b = 0; b < NB; b++) begin
                if (wea[b]) m_mem[addra][8*b +: 8] = dina[8*b +: 8];
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check("ll_valid", 32'(bus_ll.doutb_valid), 32'(ll_v));
        check("ll_data",  32'(bus_ll.doutb),       32'(ll_d));
        check("hp_valid", 32'(bus_hp.doutb_valid), 32'(hp2_v));
        check("hp_data",  32'(bus_hp.doutb),       32'(hp2_d));
        check("busy_hp",  32'(bus_hp.busy),        32'(sweep_left > 0));
        check("busy_ll",  32'(bus_ll.busy),        32'(sweep_left > 0));
    endtask

    task automatic set_idle();
        wea = '0; addra = '0; dina = '0; enb = 1'b0; addrb = '0; regceb = 1'b1;
    endtask

`ifdef FRAME_RAM_CLEAR_EN
    localparam int CD  = 16;
    localparam int CAW = 4;

    logic           rst_c;
    logic [NB-1:0]  c_wea;
    logic [CAW-1:0] c_addra;
    logic [W-1:0]   c_dina;
    logic           c_enb;
    logic [CAW-1:0] c_addrb;

    dual_port_frame_ram_if #(.RAM_WIDTH(W), .RAM_DEPTH(CD)) bus_c ();

    assign bus_c.wea    = c_wea;
    assign bus_c.addra  = c_addra;
    assign bus_c.dina   = c_dina;
    assign bus_c.enb    = c_enb;
    assign bus_c.addrb  = c_addrb;
    assign bus_c.regceb = 1'b1;

    dual_port_frame_ram #(
        .RAM_WIDTH(W), .RAM_DEPTH(CD), .RAM_PERFORMANCE("LOW_LATENCY")
    ) dut_clr (.clka(clk), .rsta_n(rst_c), .bus(bus_c));

    task automatic ctick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clr_sweep_check(input string tag, input int write_at);
        for (int k = 1; k <= CD; k++) begin
            c_wea = (k == write_at) ? 2'b11 : 2'b00;
            c_addra = '0;
            c_dina  = 16'h5555;
            ctick();
            check(tag, 32'(bus_c.busy), 32'(k < CD));
        end
        c_wea = '0;
    endtask

    task automatic clr_test();
        c_wea = '0; c_addra = '0; c_dina = '0; c_enb = 1'b0; c_addrb = '0;
        rst_c = 1'b0;
        ctick();
        check("clr_busy_in_reset", 32'(bus_c.busy), 32'd1);
        rst_c = 1'b1;
        // Write to an already-cleared word mid-sweep; it must be dropped.
        clr_sweep_check("clr_busy_sweep1", 3);
        c_enb = 1'b1; c_addrb = '0;
        ctick();
        check("clr_ignored_write", 32'(bus_c.doutb), 32'd0);
        c_enb = 1'b0;
        for (int i = 0; i < CD; i++) begin
            c_wea = 2'b11; c_addra = CAW'(i); c_dina = 16'hA000 | W'(i);
            ctick();
        end
        c_wea = '0;
        c_enb = 1'b1; c_addrb = 4'd3;
        ctick();
        check("clr_fill", 32'(bus_c.doutb), 32'hA003);
        c_enb = 1'b0;
        // Abort a sweep half way; the next one must run the full length again.
        rst_c = 1'b0; ctick(); rst_c = 1'b1;
        repeat (8) ctick();
        check("clr_busy_mid", 32'(bus_c.busy), 32'd1);
        rst_c = 1'b0; ctick(); rst_c = 1'b1;
        clr_sweep_check("clr_busy_restart", 0);
        for (int i = 0; i < CD; i++) begin
            c_enb = 1'b1; c_addrb = CAW'(i);
            ctick();
            check("clr_zero_data",  32'(bus_c.doutb),       32'd0);
            check("clr_zero_valid", 32'(bus_c.doutb_valid), 32'd1);
        end
        c_enb = 1'b0;
    endtask
`endif

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < D; i++) m_mem[i] = '0;
        ll_d = '0; ll_v = 1'b0; hp1_d = '0; hp1_v = 1'b0; hp2_d = '0; hp2_v = 1'b0;
        sweep_left = 0;
        set_idle();
        rst_n = 1'b0;
        tick();
        tick();
        check("reset_hp_doutb", 32'(bus_hp.doutb),       32'd0);
        check("reset_hp_valid", 32'(bus_hp.doutb_valid), 32'd0);
        check("reset_ll_doutb", 32'(bus_ll.doutb),       32'd0);
        check("reset_ll_valid", 32'(bus_ll.doutb_valid), 32'd0);
        rst_n = 1'b1;
        while (sweep_left > 0) tick();

        // Give the low words defined contents before anything reads them.
        for (int a = 0; a < 32; a++) begin
            wea = 2'b11; addra = AW'(a); dina = W'($urandom);
            tick();
        end

        // Basic write then read.
        wea = 2'b11; addra = 13'd5; dina = 16'hBEEF;
        tick();
        wea = '0; enb = 1'b1; addrb = 13'd5;
        tick();
        check("ll_beef_data",  32'(bus_ll.doutb),       32'hBEEF);
        check("ll_beef_valid", 32'(bus_ll.doutb_valid), 32'd1);
        enb = 1'b0;
        tick();
        check("hp_beef_data",  32'(bus_hp.doutb),       32'hBEEF);
        check("hp_beef_valid", 32'(bus_hp.doutb_valid), 32'd1);
        regceb = 1'b0;
        tick();
        check("hp_hold_data",  32'(bus_hp.doutb),       32'hBEEF);
        check("hp_hold_valid", 32'(bus_hp.doutb_valid), 32'd1);
        regceb = 1'b1;
        tick();
        check("hp_drop_valid", 32'(bus_hp.doutb_valid), 32'd0);

        // Byte enables.
        wea = 2'b11; addra = 13'd7; dina = 16'h1234;
        tick();
        wea = 2'b01; dina = 16'hABCD;
        tick();
        wea = '0; enb = 1'b1; addrb = 13'd7;
        tick();
        check("ll_byte_en", 32'(bus_ll.doutb), 32'h12CD);
        enb = 1'b0;
        tick();
        check("hp_byte_en", 32'(bus_hp.doutb), 32'h12CD);

        // Same-address read and write.
        wea = 2'b11; addra = 13'd9; dina = 16'h0001;
        tick();
        dina = 16'h00FF; enb = 1'b1; addrb = 13'd9;
        tick();
        check("ll_write_first", 32'(bus_ll.doutb), 32'h00FF);
        wea = '0; enb = 1'b0;
        tick();
        check("hp_read_first", 32'(bus_hp.doutb), 32'h0001);

        // Out of range.
        wea = 2'b11; addra = 13'd6144; dina = 16'h7777;
        tick();
        wea = '0; enb = 1'b1; addrb = 13'd6144;
        tick();
        check("ll_oor_data",  32'(bus_ll.doutb),       32'd0);
        check("ll_oor_valid", 32'(bus_ll.doutb_valid), 32'd1);
        enb = 1'b0;
        tick();
        check("hp_oor_data",  32'(bus_hp.doutb),       32'd0);
        check("hp_oor_valid", 32'(bus_hp.doutb_valid), 32'd1);

        // Random traffic on a small window so collisions are frequent.
        for (int n = 0; n < 400; n++) begin
            wea   = NB'($urandom);
            dina  = W'($urandom);
            addra = ($urandom_range(0, 7) == 0) ? AW'(D + $urandom_range(0, 2047))
                                                : AW'($urandom_range(0, 31));
            addrb = ($urandom_range(0, 7) == 0) ? AW'(D + $urandom_range(0, 2047))
                                                : AW'($urandom_range(0, 31));
            enb    = 1'($urandom_range(0, 1));
            regceb = ($urandom_range(0, 3) != 0);
            tick();
        end
        set_idle();

`ifdef FRAME_RAM_CLEAR_EN
        clr_test();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
